// File: rtl/video_compositor.sv
// video_compositor: background mode select plus priority-ordered overlay compositing.
// Two-stage pipeline: stage 1 registers the background, the masked layer hits and the layer
// colours; stage 2 composites and registers the output pixel. Sync, valid and blank are
// delayed by the same two cycles.
// Mode and layer enables are held in a shadow that loads only on new_frame_in, so a
// configuration change never tears mid-frame.
// Optional build macro ALPHA_BLEND_EN: layer 0 is averaged with whatever lies beneath it
// instead of replacing it.
module video_compositor #(
  parameter int unsigned NUM_LAYERS      = 4,
  parameter int unsigned PIXEL_WIDTH     = 24,
  parameter logic [23:0] HIGHLIGHT_COLOR = 24'hFF77AA
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic                         new_frame_in,
  input  logic [1:0]                   mode_in,
  input  logic [NUM_LAYERS-1:0]        layer_en_in,
  input  logic [PIXEL_WIDTH-1:0]       camera_pixel_in,
  input  logic [7:0]                   camera_y_in,
  input  logic                         thresholded_pixel_in,
  input  logic [NUM_LAYERS-1:0]        layer_hit_in,
  input  logic [NUM_LAYERS*24-1:0]     layer_color_in,
  input  logic                         valid_in,
  input  logic                         hsync_in,
  input  logic                         vsync_in,
  input  logic                         blank_in,
  output logic [PIXEL_WIDTH-1:0]       pixel_out,
  output logic                         valid_out,
  output logic                         hsync_out,
  output logic                         vsync_out,
  output logic                         blank_out,
  output logic [1:0]                   active_mode_out
);

  // Shadow configuration
  logic [1:0]              r_mode;
  logic [NUM_LAYERS-1:0]   r_en;

  // Stage 1
  logic [23:0]             r_bg;
  logic [NUM_LAYERS-1:0]   r_act;
  logic [NUM_LAYERS*24-1:0] r_color;
  logic                    r_valid1, r_hsync1, r_vsync1, r_blank1;

  // Combinational
  logic [23:0]             w_bg;
  logic [23:0]             w_top;
`ifdef ALPHA_BLEND_EN
  logic [23:0]             w_under;
  logic [8:0]              w_sum;
`endif

  assign active_mode_out = r_mode;

  // Shadow config loads at frame start only; a pixel in the same cycle still sees the old value
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_mode <= 2'd0;
      r_en   <= '0;
    end else if (new_frame_in) begin
      r_mode <= mode_in;
      r_en   <= layer_en_in;
    end
  end

  // Background selection from the latched mode
  always_comb begin
    w_bg = camera_pixel_in;
    unique case (r_mode)
      2'd0: w_bg = camera_pixel_in;
      2'd1: w_bg = {camera_y_in, camera_y_in, camera_y_in};
      2'd2: w_bg = thresholded_pixel_in ? HIGHLIGHT_COLOR
                                        : {camera_y_in, camera_y_in, camera_y_in};
      2'd3: w_bg = thresholded_pixel_in ? 24'hFFFFFF : 24'h000000;
    endcase
  end

  // Stage 1 registers: background, enabled hits, colours and timing signals
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_bg     <= '0;
      r_act    <= '0;
      r_color  <= '0;
      r_valid1 <= 1'b0;
      r_hsync1 <= 1'b0;
      r_vsync1 <= 1'b0;
      r_blank1 <= 1'b0;
    end else begin
      r_bg     <= w_bg;
      r_act    <= layer_hit_in & r_en;
      r_color  <= layer_color_in;
      r_valid1 <= valid_in;
      r_hsync1 <= hsync_in;
      r_vsync1 <= vsync_in;
      r_blank1 <= blank_in;
    end
  end

  // Composite: scan from lowest priority upward so the lowest active index wins
`ifdef ALPHA_BLEND_EN
  always_comb begin
    w_under = r_bg;
    w_sum   = '0;
    for (int k = NUM_LAYERS - 1; k >= 1; k--) begin
      if (r_act[k]) w_under = r_color[24*k +: 24];
    end
    w_top = w_under;
    if (r_act[0]) begin
      for (int c = 0; c < 3; c++) begin
        w_sum = {1'b0, r_color[8*c +: 8]} + {1'b0, w_under[8*c +: 8]};
        w_top[8*c +: 8] = w_sum[8:1];
      end
    end
  end
`else
  always_comb begin
    w_top = r_bg;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (r_act[k]) w_top = r_color[24*k +: 24];
    end
  end
`endif

  // Stage 2 registers: blanking forces black regardless of mode or layers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pixel_out <= '0;
      valid_out <= 1'b0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
      blank_out <= 1'b0;
    end else begin
      pixel_out <= r_blank1 ? '0 : w_top;
      valid_out <= r_valid1;
      hsync_out <= r_hsync1;
      vsync_out <= r_vsync1;
      blank_out <= r_blank1;
    end
  end

endmodule

// File: tb/tb_video_compositor.sv
// Scoreboard bench for video_compositor: expected outputs are modelled when each pixel is
// driven, queued, and compared when the pixel emerges two cycles later.
module tb_video_compositor;
  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            nf = 1'b0;
  logic [1:0]      mode = 2'd0;
  logic [N-1:0]    en = '0;
  logic [23:0]     cam = '0;
  logic [7:0]      y = '0;
  logic            th = 1'b0;
  logic [N-1:0]    hit = '0;
  logic [N*24-1:0] col = '0;
  logic            vld = 1'b0, hs = 1'b0, vs = 1'b0, blk = 1'b0;

  logic [23:0]     pixel_out;
  logic            valid_out, hsync_out, vsync_out, blank_out;
  logic [1:0]      active_mode_out;

  video_compositor #(.NUM_LAYERS(N)) dut (
    .clk_in(clk), .rst_in(rst), .new_frame_in(nf), .mode_in(mode), .layer_en_in(en),
    .camera_pixel_in(cam), .camera_y_in(y), .thresholded_pixel_in(th),
    .layer_hit_in(hit), .layer_color_in(col), .valid_in(vld), .hsync_in(hs),
    .vsync_in(vs), .blank_in(blk), .pixel_out(pixel_out), .valid_out(valid_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .blank_out(blank_out),
    .active_mode_out(active_mode_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [27:0] sb_q[$];
  logic [1:0]   m_mode = 2'd0;
  logic [N-1:0] m_en = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Reference model for the current inputs, using the model's shadow config
  function automatic logic [27:0] model();
    logic [23:0] bg, px, under;
    logic [N-1:0] act;
    logic found;
    case (m_mode)
      2'd0: bg = cam;
      2'd1: bg = {y, y, y};
      2'd2: bg = th ? 24'hFF77AA : {y, y, y};
      default: bg = th ? 24'hFFFFFF : 24'h000000;
    endcase
    act = hit & m_en;
    px = bg;
    found = 1'b0;
`ifdef ALPHA_BLEND_EN
    under = bg;
    for (int k = 1; k < N; k++) begin
      if (!found && act[k]) begin
        under = col[24*k +: 24];
        found = 1'b1;
      end
    end
    px = under;
    if (act[0]) begin
      px[23:16] = 8'((16'(col[23:16]) + 16'(under[23:16])) / 2);
      px[15:8]  = 8'((16'(col[15:8])  + 16'(under[15:8]))  / 2);
      px[7:0]   = 8'((16'(col[7:0])   + 16'(under[7:0]))   / 2);
    end
`else
    under = bg;
    for (int k = 0; k < N; k++) begin
      if (!found && act[k]) begin
        px = col[24*k +: 24];
        found = 1'b1;
      end
    end
`endif
    if (blk) px = 24'h0;
    return {blk, vs, hs, vld, px};
  endfunction

  // Push the pixel currently on the inputs, advance one cycle, compare what has matured
  task automatic step();
    logic [27:0] e;
    sb_q.push_back(model());
    if (nf) begin
      m_mode = mode;
      m_en   = en;
    end
    @(negedge clk);
    check_eq("active_mode", 32'(active_mode_out), 32'(m_mode));
    if (sb_q.size() >= 2) begin
      e = sb_q.pop_front();
      check_eq("pixel", 32'(pixel_out), 32'(e[23:0]));
      check_eq("blk_vs_hs_vld", 32'({blank_out, vsync_out, hsync_out, valid_out}),
               32'(e[27:24]));
    end
    nf = 1'b0;
  endtask

  task automatic idle();
    nf = 1'b0; hit = '0; blk = 1'b0; vld = 1'b0; hs = 1'b0; vs = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_pixel", 32'(pixel_out), 32'h0);
    check_eq("rst_sync", 32'({blank_out, vsync_out, hsync_out, valid_out}), 32'h0);
    check_eq("rst_mode", 32'(active_mode_out), 32'h0);
    rst = 1'b0;

    // 1: mode request without new_frame stays camera pass-through
    mode = 2'd2; cam = 24'h123456; y = 8'h40; th = 1'b1; vld = 1'b1;
    step();
    // 2: latch mode 2; the latching pixel still uses mode 0
    nf = 1'b1; step();
    th = 1'b1; step();
    th = 1'b0; y = 8'h40; step();
    // 3: mode 3 with layers 1,2 enabled; L1 beats L2, L0 disabled
    mode = 2'd3; en = 4'b0110; nf = 1'b1; hit = '0; step();
    col = '0; col[24 +: 24] = 24'h00FF00; col[48 +: 24] = 24'h0000FF;
    col[0 +: 24] = 24'hABCDEF; hit = 4'b0111; step();
    hit = 4'b0100; step();
    hit = 4'b0000; th = 1'b1; step();
    // 4: mid-frame mode change ignored; same-cycle pixel uses old mode
    mode = 2'd1; th = 1'b0; y = 8'h99; step();
    step();
    nf = 1'b1; step();
    step();
    // 5: blanking with hits forces black; timing signals delayed
    en = 4'b1111; nf = 1'b1; step();
    hit = 4'b1111; blk = 1'b1; hs = 1'b1; step();
    blk = 1'b0; hs = 1'b0; vs = 1'b1; vld = 1'b0; step();
    vs = 1'b0; vld = 1'b1; step();
    // 6: L0 red over camera 0000FE (replace, or average under ALPHA_BLEND_EN)
    mode = 2'd0; en = 4'b0001; nf = 1'b1; hit = '0; step();
    col[0 +: 24] = 24'hFF0000; cam = 24'h0000FE; hit = 4'b0001; step();
    en = 4'b0011; nf = 1'b1; step();
    hit = 4'b0011; step();
    idle(); step(); step();

    // Randomised traffic with occasional frame starts
    for (int i = 0; i < 300; i++) begin
      nf   = ($urandom_range(0, 15) == 0);
      mode = 2'($urandom);
      en   = N'($urandom);
      cam  = 24'($urandom);
      y    = 8'($urandom);
      th   = 1'($urandom);
      hit  = N'($urandom);
      for (int k = 0; k < N; k++) col[24*k +: 24] = 24'($urandom);
      vld = 1'($urandom); hs = 1'($urandom); vs = 1'($urandom);
      blk = ($urandom_range(0, 7) == 0);
      step();
    end

    // Reset mid-frame: pipeline and shadow clear immediately
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_pixel", 32'(pixel_out), 32'h0);
    check_eq("midrst_sync", 32'({blank_out, vsync_out, hsync_out, valid_out}), 32'h0);
    check_eq("midrst_mode", 32'(active_mode_out), 32'h0);
    sb_q.delete();
    m_mode = 2'd0; m_en = '0;
    @(negedge clk);
    rst = 1'b0;
    cam = 24'h0A0B0C; hit = '1; blk = 1'b0; vld = 1'b1; mode = 2'd3;
    step(); step(); step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/video_compositor.md
Name: video_compositor

Overview:
Parametrised, pipelined successor to the camera/crosshair pixel mux. Selects one of four background modes (camera, grayscale, threshold highlight, binary mask), then composites NUM_LAYERS priority-ordered overlay layers on top. Output is registered with fixed latency, and sync/valid are delayed to match. Sits between the camera/threshold pipeline and the HDMI/TMDS encoder. Configuration is frame-synchronous, so a mode change never tears mid-frame.

Parameters:
NUM_LAYERS, 4, number of overlay layers (1..8); layer 0 is topmost.
PIXEL_WIDTH, 24, output pixel width (RGB 8:8:8); fixed at 24 in this generation.
HIGHLIGHT_COLOR, 24'hFF77AA, colour for thresholded pixels in mode 2.

Ports:
clk_in  input  1  pixel clock
rst_in  input  1  asynchronous, active-high reset
new_frame_in  input  1  one-cycle pulse at frame start; latches configuration
mode_in  input  2  requested background mode (0 camera, 1 gray, 2 highlight, 3 mask)
layer_en_in  input  NUM_LAYERS  requested per-layer enable
camera_pixel_in  input  24  RGB camera pixel
camera_y_in  input  8  Y channel of the YCrCb conversion
thresholded_pixel_in  input  1  threshold mask bit
layer_hit_in  input  NUM_LAYERS  per-layer "pixel covered" flag, aligned with camera_pixel_in
layer_color_in  input  NUM_LAYERS*24  per-layer colour; layer k occupies bits [24k+23:24k]
valid_in  input  1  input pixel valid
hsync_in  input  1  horizontal sync
vsync_in  input  1  vertical sync
blank_in  input  1  blanking interval
pixel_out  output  24  composited pixel
valid_out  output  1  valid_in delayed 2 cycles
hsync_out  output  1  hsync_in delayed 2 cycles
vsync_out  output  1  vsync_in delayed 2 cycles
blank_out  output  1  blank_in delayed 2 cycles
active_mode_out  output  2  currently latched mode

Behaviour:
- Reset (async, rst_in=1):
  - All outputs and pipeline registers clear to 0.
  - Shadow mode = 0; shadow layer_en = all 0. After reset the block acts as camera pass-through with no overlays.
- Shadow config:
  - On a rising clk_in edge with new_frame_in=1, shadow_mode <= mode_in and shadow_en <= layer_en_in.
  - Otherwise the shadow holds. Mid-frame changes to mode_in or layer_en_in have no effect.
  - A pixel presented in the same cycle as new_frame_in uses the OLD config. The next pixel uses the new one.
  - active_mode_out = shadow_mode.
- Pipeline: advances every cycle, no stall; latency exactly 2 cycles for all data and sync outputs.
  - Stage 1 registers the background:
    - mode 0: camera_pixel_in.
    - mode 1: {Y,Y,Y}.
    - mode 2: HIGHLIGHT_COLOR if thresholded, else {Y,Y,Y}.
    - mode 3: 24'hFFFFFF if thresholded, else 24'h000000.
  - Stage 1 also registers layer_hit AND shadow_en, plus the layer colours.
  - Stage 2 composite: the lowest-index active layer wins and replaces the pixel with its colour. With no active layer, the pixel is the background.
  - If stage-2 blank is 1, pixel_out = 0 regardless of mode or layers.
- valid_in=0 pixels are still processed; only valid_out marks them.
- Reset mid-frame: the pipeline flushes to 0 immediately. The shadow returns to mode 0 until the next new_frame_in.

Optional Feature:
ALPHA_BLEND_EN.
- Defined: layer 0 is blended rather than replacing. Each channel = (layer_color + underlying) >> 1, using 9-bit intermediate sums and truncating. "Underlying" is the winning lower-priority layer or the background.
- Undefined: layer 0 replaces, like all other layers.
- Latency stays 2 in both builds.

Test Plan:
1. Reset release, mode_in=2, no new_frame_in; pixel 24'h123456, Y=8'h40, thresh=1 -> pixel_out=24'h123456 two cycles later and active_mode_out=0.
2. new_frame_in pulse with mode_in=2; next pixel has thresh=1 -> 24'hFF77AA. Next pixel has thresh=0, Y=8'h40 -> 24'h404040.
3. mode 3, layer_en=4'b0110, layer_hit=4'b0111, colours L1=24'h00FF00, L2=24'h0000FF -> 24'h00FF00 (layer 0 disabled; L1 beats L2).
4. mode_in changed mid-frame without new_frame_in -> output mode unchanged. new_frame_in and a pixel in the same cycle -> that pixel uses the old mode.
5. blank_in=1 with layer hits active -> pixel_out=0; hsync, vsync, valid and blank outputs equal their inputs delayed exactly 2 cycles.
6. ALPHA_BLEND_EN build: L0=24'hFF0000 over camera 24'h0000FE -> 24'h7F007F. Without the macro -> 24'hFF0000.
